// File: rtl/mac_accumulator.sv
// mac_accumulator: chunk-serial wide accumulator for MAC product terms with sticky overflow
module mac_accumulator #(
    parameter int PROD_W  = 512,
    parameter int ACC_W   = 576,
    parameter int CHUNK_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_first,
    input  logic              prod_last,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_ovf,
    output logic              busy
);
    localparam int NCHUNK = ACC_W / CHUNK_W;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, ADD, OUT} state_t;
    state_t            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  p_q;
    logic [KW-1:0]     k_q;
    logic              carry_q;
    logic              ovf_q;
    logic              last_q;
    logic [CHUNK_W:0]  sum_d;
    // One slice per cycle; the carry register links consecutive slices.
    always_comb begin
        sum_d = {1'b0, acc_q[int'(k_q)*CHUNK_W +: CHUNK_W]} + {1'b0, p_q[int'(k_q)*CHUNK_W +: CHUNK_W]} + (CHUNK_W+1)'(carry_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            p_q     <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (prod_valid) begin
                    p_q     <= ACC_W'(prod);
                    last_q  <= prod_last;
                    k_q     <= '0;
                    carry_q <= 1'b0;
                    if (prod_first) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                    end
                    state_q <= ADD;
                end
                ADD: begin
                    acc_q[int'(k_q)*CHUNK_W +: CHUNK_W] <= sum_d[CHUNK_W-1:0];
                    carry_q <= sum_d[CHUNK_W];
                    k_q     <= k_q + 1'b1;
                    if (k_q == KW'(NCHUNK-1)) begin
                        ovf_q   <= ovf_q | sum_d[CHUNK_W];
                        state_q <= last_q ? OUT : IDLE;
                    end
                end
                OUT: if (acc_ready) begin
                    acc_q   <= '0;
                    ovf_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign prod_ready = state_q == IDLE;
    assign acc_valid  = state_q == OUT;
    assign busy       = state_q != IDLE;
    assign acc_out    = acc_q;
    assign acc_ovf    = ovf_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed vectors for the default and a small overflow-prone configuration
module tb_mac_accumulator;
    logic         clk = 1'b0;
    logic         rst;
    logic         pv, pr, pf, pl, av, ar, ovf, bz;
    logic [511:0] p;
    logic [575:0] ao;
    logic         s_pv, s_pr, s_pf, s_pl, s_av, s_ar, s_ovf, s_bz;
    logic [63:0]  s_p, s_ao;
    logic [575:0] e;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    mac_accumulator dut (
        .clk(clk), .rst(rst), .prod_valid(pv), .prod_ready(pr), .prod(p),
        .prod_first(pf), .prod_last(pl), .acc_valid(av), .acc_ready(ar),
        .acc_out(ao), .acc_ovf(ovf), .busy(bz)
    );

    mac_accumulator #(.PROD_W(64), .ACC_W(64), .CHUNK_W(16)) dut_s (
        .clk(clk), .rst(rst), .prod_valid(s_pv), .prod_ready(s_pr), .prod(s_p),
        .prod_first(s_pf), .prod_last(s_pl), .acc_valid(s_av), .acc_ready(s_ar),
        .acc_out(s_ao), .acc_ovf(s_ovf), .busy(s_bz)
    );

    task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one term from IDLE, then counts cycles after the accept edge until OUT or IDLE.
    task automatic term(input bit sm, input logic [511:0] v, input bit f, input bit l, input int exp_cyc, input string tag);
        int cyc;
        if (sm) begin
            s_p = v[63:0]; s_pf = f; s_pl = l; s_pv = 1'b1;
        end else begin
            p = v; pf = f; pl = l; pv = 1'b1;
        end
        step();
        pv = 1'b0;
        s_pv = 1'b0;
        cyc = 1;
        while (cyc <= 40 && !(sm ? (s_av || s_pr) : (av || pr))) begin
            step();
            cyc++;
        end
        chk({tag, "_cyc"}, 576'(cyc), 576'(exp_cyc));
        chk({tag, "_valid"}, 576'(sm ? s_av : av), 576'(l));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pv = 0; pf = 0; pl = 0; p = '0; ar = 1'b1;
        s_pv = 0; s_pf = 0; s_pl = 0; s_p = '0; s_ar = 1'b1;
        repeat (2) step();
        chk("rst_ready", 576'(pr), 576'(1));
        chk("rst_valid", 576'(av), 576'(0));
        chk("rst_acc", ao, '0);
        chk("rst_ovf", 576'(ovf), 576'(0));
        chk("rst_busy", 576'(bz), 576'(0));
        rst = 1'b0;

        term(0, 512'd50, 1, 1, 10, "single");
        chk("single_acc", ao, 576'd50);
        chk("single_ovf", 576'(ovf), 576'(0));
        chk("single_busy", 576'(bz), 576'(1));
        step();
        chk("single_ready_back", 576'(pr), 576'(1));
        chk("single_valid_drop", 576'(av), 576'(0));

        term(0, 512'd50, 1, 0, 10, "three_a");
        term(0, 512'd50, 0, 0, 10, "three_b");
        term(0, 512'd50, 0, 1, 10, "three_c");
        chk("three_acc", ao, 576'd150);
        step();

        term(0, 512'd5, 0, 1, 10, "nofirst");
        chk("nofirst_acc", ao, 576'd5);
        step();

        term(0, 512'hFFFF_FFFF_FFFF_FFFF, 1, 0, 10, "carry_a");
        term(0, 512'd1, 0, 1, 10, "carry_b");
        e = '0;
        e[64] = 1'b1;
        chk("carry_acc", ao, e);
        chk("carry_ovf", 576'(ovf), 576'(0));
        step();

        ar = 1'b0;
        term(0, 512'd9, 1, 1, 10, "bp");
        p = 512'd100; pf = 1'b1; pl = 1'b1; pv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 576'(av), 576'(1));
            chk("bp_hold", ao, 576'd9);
            chk("bp_ready", 576'(pr), 576'(0));
        end
        ar = 1'b1;
        step();
        chk("bp_hs_ready", 576'(pr), 576'(1));
        chk("bp_hs_valid", 576'(av), 576'(0));
        term(0, 512'd100, 1, 1, 10, "bp_next");
        chk("bp_next_acc", ao, 576'd100);
        step();

        p = '1; pf = 1'b1; pl = 1'b1; pv = 1'b1;
        step();
        pv = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_acc", ao, '0);
        chk("midrst_ovf", 576'(ovf), 576'(0));
        chk("midrst_ready", 576'(pr), 576'(1));
        chk("midrst_busy", 576'(bz), 576'(0));
        term(0, 512'd7, 1, 1, 10, "post_rst");
        chk("post_rst_acc", ao, 576'd7);
        step();

        term(1, 512'hFFFF_FFFF_FFFF_FFFF, 1, 0, 5, "small_a");
        term(1, 512'd1, 0, 1, 5, "small_b");
        chk("small_wrap_acc", 576'(s_ao), 576'd0);
        chk("small_wrap_ovf", 576'(s_ovf), 576'(1));
        step();
        term(1, 512'd3, 1, 1, 5, "small_c");
        chk("small_next_acc", 576'(s_ao), 576'd3);
        chk("small_next_ovf", 576'(s_ovf), 576'(0));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
